window_generator: RTL and testbench
===================================

# window_generator

Streaming sliding-window generator that sits directly upstream of `kernel_convolution`. It accepts one raster-ordered pixel per valid cycle, stores the previous `KERNEL_SIZE-1` image rows in line buffers, and presents a `KERNEL_SIZE x KERNEL_SIZE` neighbourhood on `window_out` in the `[row][col]` layout that `kernel_convolution` takes on `buffer_in`. Only fully-interior windows are flagged valid; there is no edge padding.

## Interface
- `KERNEL_SIZE`, 3: window edge length; must be at least 2.
- `WORD_SIZE`, 16: pixel width; signed.
- `IMAGE_WIDTH`, 640: pixels per row.
- `IMAGE_HEIGHT`, 480: rows per frame.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pixel_in`  in  signed `[WORD_SIZE-1:0]`  incoming pixel.
- `pixel_valid`  in  1  `pixel_in` is accepted on this edge; there is no backpressure.
- `sof`  in  1  start of frame; only meaningful when `pixel_valid` is high.
- `window_out`  out  signed `[WORD_SIZE-1:0] [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]`  neighbourhood; `[KERNEL_SIZE-1][KERNEL_SIZE-1]` is the newest pixel (bottom-right).
- `window_valid`  out  1  one-cycle qualifier for `window_out`.
- `out_row`  out  `$clog2(IMAGE_HEIGHT)`  row of the bottom-right pixel.
- `out_col`  out  `$clog2(IMAGE_WIDTH)`  column of the bottom-right pixel.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- **Position counters.** `col_cnt` runs 0..IMAGE_WIDTH-1 and `row_cnt` runs 0..IMAGE_HEIGHT-1. Both advance only on accepted pixels. When `col_cnt` wraps to 0, `row_cnt` increments. After pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), both counters return to 0.
- **sof.** `sof` together with `pixel_valid` forces the accepted pixel to position (0,0), including mid-frame; the counters restart from there. `sof` without `pixel_valid` is ignored. Line buffer contents are not cleared; stale data is masked by the validity rule below.
- **Line buffers.** On each accepted pixel at column c:
  - read the pixels at column c of the K-1 previous rows (read-first);
  - write `pixel_in` into the newest line at column c, shifting the column chain up by one row.
- **Window shift.** The window shifts left by one column. The new rightmost column is `[0]` = oldest row down to `[K-1]` = `pixel_in`.
- **Validity.** `window_valid` is high for the accepted pixel at (r,c) iff r >= K-1 and c >= K-1. This gives (IMAGE_HEIGHT-K+1) x (IMAGE_WIDTH-K+1) valid windows per frame. Columns shifted in from the previous row's tail are never flagged valid.
- **Gaps.** When `pixel_valid` is low, all storage holds and `window_valid` and `frame_done` are low.
- **Arithmetic.** Pixels pass through unmodified; there is no arithmetic on pixel data.

## Timing
- Base latency: the window for a pixel accepted at edge N is visible, with `window_valid`, `out_row`/`out_col`, and `frame_done`, after edge N. These outputs are registered.
- Throughput: one window per clock at full rate.
- Reset: asserting `reset_n` low immediately clears every output to 0, including all `window_out` elements, and clears the counters. Line buffer RAM need not be cleared.
- Reset mid-frame: the next accepted pixel is treated as (0,0) whether or not `sof` is present.
- Simultaneous `sof` and column/row wrap: `sof` wins.

## Configuration
- `WINDOW_GENERATOR_OUT_REG_EN`:
  - Defined: one extra register stage on `window_out`, `window_valid`, `out_row`, `out_col`, and `frame_done`, giving 2-cycle latency. This stage also advances during input gaps, so `window_valid` deasserts on schedule.
  - Undefined: 1-cycle latency as specified above.
  - Reset behaviour is identical in both builds.

## Structure
- Package `image_pkg` holds:
  - default `KERNEL_SIZE`, `WORD_SIZE`, `IMAGE_WIDTH`, `IMAGE_HEIGHT` constants;
  - a `pixel_t` typedef (signed `WORD_SIZE`);
  - coordinate-width localparams derived with `$clog2`.
- Sub-module `line_buffer`: a single-row, IMAGE_WIDTH-deep read-first RAM with write enable. The top level instantiates K-1 of these.

## Test plan
All scenarios use K=3, WORD_SIZE=8, IMAGE_WIDTH=4, IMAGE_HEIGHT=4, and pixel value = 10*row + col.

- **Reset:** hold `reset_n`=0 for 3 cycles → all outputs 0, `window_valid`=0.
- **Full frame at full rate, starting with `sof`:**
  - first `window_valid` appears one cycle after pixel 22 is accepted;
  - `window_out` = {{0,1,2},{10,11,12},{20,21,22}};
  - exactly 4 valid windows per frame (bottom-right pixels 22, 23, 32, 33);
  - `frame_done` pulses once after 33.
- **Same frame with random `pixel_valid` gaps:** the same 4 windows appear in the same order with the same contents, and no valid asserts during gaps.
- **`sof` reasserted at pixel 21:** the counters restart; no `window_valid` until new position (2,2); the following window contents come from post-`sof` data only.
- **`reset_n` pulsed low mid-frame at pixel 12:** outputs clear immediately; a subsequent frame without `sof` produces the correct 4 windows.
- **`WINDOW_GENERATOR_OUT_REG_EN` build:** the full-frame scenario gives identical windows, each delayed by exactly one more cycle.

Source files
------------

// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
//   Shared image-pipeline definitions: default geometry and pixel width, the
//   pixel type, coordinate widths and a small address-width helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package image_pkg;

    localparam int DEFAULT_KERNEL_SIZE  = 3;
    localparam int DEFAULT_WORD_SIZE    = 16;
    localparam int DEFAULT_IMAGE_WIDTH  = 640;
    localparam int DEFAULT_IMAGE_HEIGHT = 480;

    typedef logic signed [DEFAULT_WORD_SIZE-1:0] pixel_t;

    localparam int DEFAULT_ROW_W = $clog2(DEFAULT_IMAGE_HEIGHT);
    localparam int DEFAULT_COL_W = $clog2(DEFAULT_IMAGE_WIDTH);

    // Address width for a memory of the given depth, never below one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
//   One image row of storage, DEPTH words deep, read-first.
//   The read is combinational so the old contents of the addressed column are
//   available in the same cycle that the new pixel is written there.
//
// Ports
//   clk      in   clock; write happens on the rising edge
//   we       in   write enable
//   addr     in   column address (shared by read and write)
//   wr_data  in   word written at addr when we is high
//   rd_data  out  word currently stored at addr (value before this edge's write)
// -----------------------------------------------------------------------------
module line_buffer
    import image_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_IMAGE_WIDTH,
    parameter int WIDTH  = DEFAULT_WORD_SIZE,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window_generator.sv
// -----------------------------------------------------------------------------
// window_generator
//   Streaming sliding-window generator for raster-ordered pixels. Keeps the
//   previous KERNEL_SIZE-1 rows in line buffers and presents a
//   KERNEL_SIZE x KERNEL_SIZE neighbourhood in [row][col] layout, with
//   [KERNEL_SIZE-1][KERNEL_SIZE-1] being the newest pixel. Only fully interior
//   windows are flagged valid (no edge padding).
//
// Build option
//   WINDOW_GENERATOR_OUT_REG_EN  defined: one extra free-running output
//                                register stage (2-cycle latency).
//                                undefined: 1-cycle latency.
//
// Ports
//   clk          in   sole clock
//   reset_n      in   asynchronous active-low reset
//   pixel_in     in   incoming pixel (signed)
//   pixel_valid  in   pixel_in accepted on this edge (no backpressure)
//   sof          in   start of frame, qualified by pixel_valid
//   window_out   out  neighbourhood, [row][col], bottom-right newest
//   window_valid out  one-cycle qualifier for window_out
//   out_row      out  row of the bottom-right pixel
//   out_col      out  column of the bottom-right pixel
//   frame_done   out  one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_generator
    import image_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEFAULT_KERNEL_SIZE,
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT
) (
    input  logic                                                 clk,
    input  logic                                                 reset_n,
    input  logic signed [WORD_SIZE-1:0]                          pixel_in,
    input  logic                                                 pixel_valid,
    input  logic                                                 sof,
    output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window_out,
    output logic                                                 window_valid,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]                      out_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]                       out_col,
    output logic                                                 frame_done
);

    localparam int ROW_W     = $clog2(IMAGE_HEIGHT);
    localparam int COL_W     = $clog2(IMAGE_WIDTH);
    localparam int NUM_LINES = KERNEL_SIZE - 1;

    typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window_t;

    // ---------------------------------------------------------------------
    // Position tracking
    // ---------------------------------------------------------------------
    logic [ROW_W-1:0] row_cnt_reg, row_cnt_next, cur_row;
    logic [COL_W-1:0] col_cnt_reg, col_cnt_next, cur_col;
    logic             last_row, last_col, in_window;

    // sof relocates the current pixel to (0,0); it also takes priority over
    // any wrap the counters would otherwise perform.
    always_comb begin
        cur_row      = sof ? '0 : row_cnt_reg;
        cur_col      = sof ? '0 : col_cnt_reg;
        last_row     = (cur_row == ROW_W'(IMAGE_HEIGHT - 1));
        last_col     = (cur_col == COL_W'(IMAGE_WIDTH - 1));
        in_window    = (cur_row >= ROW_W'(KERNEL_SIZE - 1)) &&
                       (cur_col >= COL_W'(KERNEL_SIZE - 1));
        row_cnt_next = row_cnt_reg;
        col_cnt_next = col_cnt_reg;
        if (pixel_valid) begin
            if (last_col) begin
                col_cnt_next = '0;
                row_cnt_next = last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_cnt_next = cur_col + COL_W'(1);
                row_cnt_next = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt_reg <= '0;
            col_cnt_reg <= '0;
        end else begin
            row_cnt_reg <= row_cnt_next;
            col_cnt_reg <= col_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Line buffers: col_data[0] is the oldest stored row, col_data[K-1] the
    // incoming pixel. Each buffer is rewritten with the row below it, so the
    // column chain moves up by one row on every accepted pixel.
    // ---------------------------------------------------------------------
    logic [WORD_SIZE-1:0] col_data [KERNEL_SIZE];

    assign col_data[KERNEL_SIZE-1] = pixel_in;

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            line_buffer #(
                .DEPTH  (IMAGE_WIDTH),
                .WIDTH  (WORD_SIZE),
                .ADDR_W (COL_W)
            ) u_line_buffer (
                .clk     (clk),
                .we      (pixel_valid),
                .addr    (cur_col),
                .wr_data (col_data[gi+1]),
                .rd_data (col_data[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Window shift register: shift left, new column enters on the right.
    // ---------------------------------------------------------------------
    window_t win_reg, win_next;

    generate
        for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_win_row
            for (genvar gj = 0; gj < KERNEL_SIZE; gj++) begin : g_win_col
                if (gj == KERNEL_SIZE - 1) begin : g_new
                    assign win_next[gi][gj] = col_data[gi];
                end else begin : g_shift
                    assign win_next[gi][gj] = win_reg[gi][gj+1];
                end
            end
        end
    endgenerate

    logic             valid_reg;
    logic             done_reg;
    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            row_reg   <= '0;
            col_reg   <= '0;
        end else begin
            valid_reg <= pixel_valid && in_window;
            done_reg  <= pixel_valid && last_row && last_col;
            if (pixel_valid) begin
                win_reg <= win_next;
                row_reg <= cur_row;
                col_reg <= cur_col;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output stage
    // ---------------------------------------------------------------------
`ifdef WINDOW_GENERATOR_OUT_REG_EN
    // Free-running: follows stage one every cycle, so the valid and done
    // pulses stay single-cycle even across input gaps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_out   <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
        end else begin
            window_out   <= win_reg;
            window_valid <= valid_reg;
            frame_done   <= done_reg;
            out_row      <= row_reg;
            out_col      <= col_reg;
        end
    end
`else
    assign window_out   = win_reg;
    assign window_valid = valid_reg;
    assign frame_done   = done_reg;
    assign out_row      = row_reg;
    assign out_col      = col_reg;
`endif

endmodule

// File: tb/tb_window_generator.sv
// -----------------------------------------------------------------------------
// tb_window_generator
//   Scoreboard bench for window_generator with K=3, 8-bit pixels, 4x4 image,
//   pixel value = 10*row + col (+ optional bias). Build with
//   WINDOW_GENERATOR_OUT_REG_EN defined to exercise the 2-cycle build.
// -----------------------------------------------------------------------------
module tb_window_generator;

    localparam int K  = 3;
    localparam int WS = 8;
    localparam int IW = 4;
    localparam int IH = 4;
`ifdef WINDOW_GENERATOR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef logic [K-1:0][K-1:0][WS-1:0] win_t;

    logic                          clk = 1'b0;
    logic                          reset_n = 1'b0;
    logic signed [WS-1:0]          pixel_in = '0;
    logic                          pixel_valid = 1'b0;
    logic                          sof = 1'b0;
    logic signed [K-1:0][K-1:0][WS-1:0] window_out;
    logic                          window_valid;
    logic [1:0]                    out_row;
    logic [1:0]                    out_col;
    logic                          frame_done;

    window_generator #(
        .KERNEL_SIZE  (K),
        .WORD_SIZE    (WS),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .sof          (sof),
        .window_out   (window_out),
        .window_valid (window_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int   cyc;
        win_t win;
        int   row;
        int   col;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    win_t win_log[$];
    int   img [IH][IW];
    int   m_row = 0;
    int   m_col = 0;
    int   win_seen = 0;
    int   done_seen = 0;

    task automatic clear_img();
        for (int i = 0; i < IH; i++)
            for (int j = 0; j < IW; j++)
                img[i][j] = -1;
    endtask

    task automatic send(input bit s, input int bias);
        exp_t e;
        int   val;
        @(negedge clk);
        if (s) begin
            m_row = 0;
            m_col = 0;
            clear_img();
        end
        val         = 10 * m_row + m_col + bias;
        pixel_in    = WS'(val);
        pixel_valid = 1'b1;
        sof         = s;
        img[m_row][m_col] = val;
        if (m_row >= K - 1 && m_col >= K - 1) begin
            e.cyc = cyc + LAT;
            e.row = m_row;
            e.col = m_col;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    e.win[i][j] = WS'(img[m_row - (K - 1) + i][m_col - (K - 1) + j]);
            exp_q.push_back(e);
        end
        if (m_row == IH - 1 && m_col == IW - 1)
            done_q.push_back(cyc + LAT);
        if (m_col == IW - 1) begin
            m_col = 0;
            m_row = (m_row == IH - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            sof         = 1'b0;
        end
    endtask

    // Output monitor: every valid window must match the scoreboard head and
    // appear on exactly the scheduled cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("win_valid", window_valid, 1'b1);
                check("win_data", $unsigned(window_out), e.win);
                check("win_row", out_row, e.row);
                check("win_col", out_col, e.col);
            end else if (window_valid) begin
                check("win_spurious", window_valid, 1'b0);
            end
            if (window_valid) begin
                win_seen++;
                win_log.push_back($unsigned(window_out));
            end
            if (done_q.size() > 0 && done_q[0] <= cyc) begin
                void'(done_q.pop_front());
                check("frame_done", frame_done, 1'b1);
            end else if (frame_done) begin
                check("done_spurious", frame_done, 1'b0);
            end
            if (frame_done) done_seen++;
        end
    end

    task automatic run_frame(input bit first_sof, input bit gaps);
        for (int p = 0; p < IW * IH; p++) begin
            send(first_sof && (p == 0), 0);
            if (gaps) idle($urandom_range(0, 2));
        end
        idle(4);
    endtask

    task automatic phase_end(input string tag, input int w0, input int d0);
        check({tag, "_win_count"}, win_seen - w0, 4);
        check({tag, "_done_count"}, done_seen - d0, 1);
        check({tag, "_q_empty"}, exp_q.size() + done_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   w0, d0;
        win_t first_exp;

        clear_img();
        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_window", $unsigned(window_out), 0);
        check("rst_valid", window_valid, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_done", frame_done, 0);
        reset_n = 1'b1;
        idle(2);

        // Full frame at full rate
        w0 = win_seen; d0 = done_seen;
        run_frame(1'b1, 1'b0);
        phase_end("full", w0, d0);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                first_exp[i][j] = WS'(10 * i + j);
        check("first_window", win_log[w0], first_exp);
        $display("phase full-rate: %0d windows", win_seen - w0);

        // Same frame with random gaps
        w0 = win_seen; d0 = done_seen;
        run_frame(1'b1, 1'b1);
        phase_end("gaps", w0, d0);
        $display("phase gaps: %0d windows", win_seen - w0);

        // sof reasserted at pixel 21 (position (2,1) of a biased partial frame)
        w0 = win_seen; d0 = done_seen;
        send(1'b1, 50);
        for (int p = 1; p < 2 * IW + 1; p++) send(1'b0, 50);
        run_frame(1'b1, 1'b0);
        phase_end("sof", w0, d0);
        $display("phase sof-restart: %0d windows", win_seen - w0);

        // Reset pulsed mid-frame after pixel 12, next frame without sof
        w0 = win_seen; d0 = done_seen;
        send(1'b1, 0);
        for (int p = 1; p < IW + 3; p++) send(1'b0, 0);
        idle(2);
        check("pre_rst_row", out_row, 1);
        check("pre_rst_col", out_col, 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_window", $unsigned(window_out), 0);
        check("mid_rst_row", out_row, 0);
        check("mid_rst_col", out_col, 0);
        check("mid_rst_valid", window_valid, 0);
        m_row = 0;
        m_col = 0;
        clear_img();
        idle(2);
        reset_n = 1'b1;
        run_frame(1'b0, 1'b0);
        phase_end("rst", w0, d0);
        $display("phase mid-reset: %0d windows", win_seen - w0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
